// File: rtl/tt_pkg.sv
// Shared types and sizing helpers for the truth-table sweeper.
package tt_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Truth-table width for an n_in-input function.
  function automatic int unsigned tt_width(input int unsigned n_in);
    return 32'd1 << n_in;
  endfunction

  // Bits needed for a counter running 0..settle-1 (at least one bit).
  function automatic int unsigned settle_cnt_w(input int unsigned settle);
    return (settle <= 1) ? 1 : $clog2(settle);
  endfunction

endpackage

// File: rtl/truth_table_sweeper_if.sv
// Requester / function-under-test bundle for truth_table_sweeper.
// Optional compare signals exist only when TT_COMPARE_EN is defined.
interface truth_table_sweeper_if #(
  parameter int unsigned N_IN = 4
);
  import tt_pkg::*;

  localparam int unsigned TW = tt_width(N_IN);

  logic            start;
  logic            busy;
  logic            done;
  logic [N_IN-1:0] x;
  logic            f;
  logic [TW-1:0]   table_q;
`ifdef TT_COMPARE_EN
  logic [TW-1:0]   expected;
  logic            pass;
  logic [N_IN-1:0] first_fail;
`endif

`ifdef TT_COMPARE_EN
  modport master (
    output start, f, expected,
    input  busy, done, x, table_q, pass, first_fail
  );
  modport slave (
    input  start, f, expected,
    output busy, done, x, table_q, pass, first_fail
  );
`else
  modport master (
    output start, f,
    input  busy, done, x, table_q
  );
  modport slave (
    input  start, f,
    output busy, done, x, table_q
  );
`endif

endinterface

// File: rtl/tt_settle_timer.sv
// Settle-window counter: runs 0..SETTLE-1 while enabled, pulses tc on the
// last count and wraps to 0.
module tt_settle_timer
  import tt_pkg::*;
#(
  parameter int unsigned SETTLE = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic tc
);

  localparam int unsigned   CW   = settle_cnt_w(SETTLE);
  localparam logic [CW-1:0] LAST = CW'(SETTLE - 1);

  logic [CW-1:0] cnt_q;

  assign tc = en && (cnt_q == LAST);

  // Count while enabled; clear on reset or a new sweep.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= tc ? '0 : cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/truth_table_sweeper.sv
// Exhaustive truth-table sweeper: drives x = 0..2^N_IN-1, holds each vector
// for SETTLE cycles and captures f into table_q.
// Optional golden compare enabled by defining TT_COMPARE_EN.
module truth_table_sweeper
  import tt_pkg::*;
#(
  parameter int unsigned N_IN   = 4,
  parameter int unsigned SETTLE = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  truth_table_sweeper_if.slave  bus
);

  localparam int unsigned     TW       = tt_width(N_IN);
  localparam logic [N_IN:0]   LAST_IDX = (N_IN + 1)'(TW - 1);

  state_e          state_q, state_d;
  logic [N_IN:0]   idx_q;
  logic [TW-1:0]   table_q;
  logic            accept;
  logic            run_en;
  logic            tc;
  logic            last;
  logic            busy;
  logic            done;
  logic [N_IN-1:0] x;

  assign accept = (state_q == IDLE) && bus.start;
  assign run_en = (state_q == RUN);
  assign last   = tc && (idx_q == LAST_IDX);

  tt_settle_timer #(.SETTLE(SETTLE)) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clear (accept),
    .en    (run_en),
    .tc    (tc)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state and state-decoded outputs.
  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    x       = '0;
    case (state_q)
      IDLE: begin
        if (bus.start) state_d = RUN;
      end
      RUN: begin
        busy = 1'b1;
        x    = idx_q[N_IN-1:0];
        if (last) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Vector index and truth-table capture.
  always_ff @(posedge clk) begin
    if (rst || accept) begin
      idx_q   <= '0;
      table_q <= '0;
    end else if (run_en && tc) begin
      table_q[idx_q[N_IN-1:0]] <= bus.f;
      if (!last) idx_q <= idx_q + (N_IN + 1)'(1);
    end
  end

  assign bus.busy    = busy;
  assign bus.done    = done;
  assign bus.x       = x;
  assign bus.table_q = table_q;

`ifdef TT_COMPARE_EN
  logic [TW-1:0]   table_final;
  logic [TW-1:0]   mismatch;
  logic [N_IN-1:0] ff_d;
  logic            found;
  logic            pass_q;
  logic [N_IN-1:0] ff_q;

  // Result is registered at the last sample edge so it is already valid in
  // the DONE cycle; the final bit therefore comes straight from f.
  always_comb begin
    table_final       = table_q;
    table_final[TW-1] = bus.f;
    mismatch          = table_final ^ bus.expected;
    ff_d              = '0;
    found             = 1'b0;
    for (int unsigned i = 0; i < TW; i++) begin
      if (!found && mismatch[i]) begin
        ff_d  = N_IN'(i);
        found = 1'b1;
      end
    end
  end

  // Compare result register, held until the next start or reset.
  always_ff @(posedge clk) begin
    if (rst || accept) begin
      pass_q <= 1'b0;
      ff_q   <= '0;
    end else if (run_en && last) begin
      pass_q <= !found;
      ff_q   <= ff_d;
    end
  end

  assign bus.pass       = pass_q;
  assign bus.first_fail = ff_q;
`endif

endmodule
